// File: rtl/adder_pkg.sv
// Shared definitions for the segmented add/subtract unit.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
// Contents: FSM state encoding, segment-count helper, slice-counter width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of SEG_WIDTH slices in a WIDTH-bit operand. A zero SEG_WIDTH
  // returns 0 so the caller's configuration check can flag it cleanly.
  function automatic int nseg(input int width, input int seg_width);
    return (seg_width > 0) ? (width / seg_width) : 0;
  endfunction

  // Slice counter width: $clog2(n), but never below one bit so NSEG=1 still
  // gets a real (constant-zero) counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_SEG_WIDTH = 8;
  localparam int DEF_NSEG      = nseg(DEF_WIDTH, DEF_SEG_WIDTH);
  localparam int DEF_CNT_W     = cnt_width(DEF_NSEG);

endpackage

// File: rtl/seg_full_adder.sv
// Combinational SEG_WIDTH-bit ripple-carry adder built from full adders.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a, b (SEG_WIDTH) and cin in; s (SEG_WIDTH) and cout out.
module seg_full_adder #(
  parameter int SEG_WIDTH = 8
) (
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [SEG_WIDTH-1:0] s,
  output logic                 cout
);

  // The carry rides in a block-local variable rather than a vector so the
  // ripple does not look like a combinational self-loop on one signal.
  always_comb begin : ripple
    logic c;
    c = cin;
    for (int i = 0; i < SEG_WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seg_adder.sv
// Multi-cycle add/subtract unit: one SEG_WIDTH slice per clock, inter-slice carry registered.
// Latency: out_valid rises NSEG edges after the accept edge; throughput NSEG+1 cycles back-to-back.
// Backpressure: result held in DONE while out_ready=0; in_ready only in IDLE or when the result is consumed.
// Ports: clk, reset (sync, active-high); in_valid/in_ready with a, b, sub, cin;
//        out_valid/out_ready with sum, cout, ovf, zero.
// Build option: define SEG_ADDER_SAT_EN to saturate sum on signed overflow.
module seg_adder
  import adder_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SEG_WIDTH = DEF_SEG_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG  = nseg(WIDTH, SEG_WIDTH);
  localparam int CNT_W = cnt_width(NSEG);
  localparam int MSB   = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NSEG - 1);

  if (SEG_WIDTH <= 0 || WIDTH <= 0 || NSEG * SEG_WIDTH != WIDTH) begin : g_bad_cfg
    $error("seg_adder: WIDTH must be a nonzero multiple of SEG_WIDTH");
  end

`ifdef SEG_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;      // b already inverted for subtract
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SEG_WIDTH-1:0] a_sl, b_sl, s_sl;
  logic                 c_sl;
  logic                 accept;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  // Slice k of the latched operands feeds the single shared adder.
  always_comb begin
    a_sl = a_q[int'(k_q)*SEG_WIDTH +: SEG_WIDTH];
    b_sl = b_q[int'(k_q)*SEG_WIDTH +: SEG_WIDTH];
  end

  seg_full_adder #(
    .SEG_WIDTH(SEG_WIDTH)
  ) u_slice (
    .a   (a_sl),
    .b   (b_sl),
    .cin (carry_q),
    .s   (s_sl),
    .cout(c_sl)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: ;
      RUN: begin
        sum_d[int'(k_q)*SEG_WIDTH +: SEG_WIDTH] = s_sl;
        carry_d = c_sl;
        if (k_q == LAST_K) begin
          cout_d  = c_sl;
          // Operands of equal sign whose result sign differs from A.
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (s_sl[SEG_WIDTH-1] != a_q[MSB]);
          state_d = DONE;
`ifdef SEG_ADDER_SAT_EN
          if (ovf_d) begin
            sum_d = a_q[MSB] ? SAT_NEG : SAT_POS;
          end
`endif
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // accept can only be true in IDLE or in DONE with out_ready, so this
    // overrides the DONE->IDLE exit for the back-to-back case.
    if (accept) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
      k_d     = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = ~|sum_q;

endmodule

// File: tb/tb_seg_adder.sv
// Scoreboard bench for seg_adder: randomized and directed operations against an arithmetic model.
// Latency: checks out_valid rises NSEG edges after each accept.
// Backpressure: exercises held results, back-to-back accept and random out_ready.
module tb_seg_adder;

  localparam int W    = 32;
  localparam int SW   = 8;
  localparam int NSEG = W / SW;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         sub, cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf, zero;

  always #5 clk = ~clk;

  seg_adder #(.WIDTH(W), .SEG_WIDTH(SW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           acc_edge;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   edges = 0;
  logic rnd_bp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the true values of the operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic c);
    exp_t e;
    longint          sx, sy, sr;
    longint unsigned ux, uy, ur;
    longint          max_s, min_s;
    max_s = (longint'(1) <<< (W - 1)) - 1;
    min_s = -(longint'(1) <<< (W - 1));
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      sr     = sx - sy;
      ur     = ux - uy;
      e.cout = (ux >= uy);
    end else begin
      sr     = sx + sy + longint'(c);
      ur     = ux + uy + longint'(c);
      e.cout = (ur >= (longint'(1) <<< W));
    end
    e.sum = ur[W-1:0];
    e.ovf = (sr > max_s) || (sr < min_s);
`ifdef SEG_ADDER_SAT_EN
    if (e.ovf) e.sum = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    e.zero     = (e.sum == '0);
    e.acc_edge = 0;
    return e;
  endfunction

  always @(posedge clk) edges <= edges + 1;

  // Monitor: samples on the falling edge, pops on every consumed result,
  // pushes the model's answer on every accept.
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [W-1:0] prev_sum   = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          if (!prev_valid) chk("latency", 64'(edges - q[0].acc_edge), 64'(NSEG));
          if (prev_valid && !prev_ready) chk("hold_sum", 64'(sum), 64'(prev_sum));
          if (out_ready) begin
            e = q.pop_front();
            chk("sum",  64'(sum),  64'(e.sum));
            chk("cout", 64'(cout), 64'(e.cout));
            chk("ovf",  64'(ovf),  64'(e.ovf));
            chk("zero", 64'(zero), 64'(e.zero));
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(a, b, sub, cin);
        e.acc_edge = edges + 1;
        q.push_back(e);
      end
    end
    prev_valid <= out_valid;
    prev_ready <= out_ready;
    prev_sum   <= sum;
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input logic c, output int waits);
    logic ok;
    a = x; b = y; sub = s; cin = c; in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
      if (ok) break;
      waits++;
      if (waits > 300) begin
        chk("accept_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
      out_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int w;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_sum",       64'(sum),       64'd0);
    chk("rst_cout",      64'(cout),      64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    chk("rst_zero",      64'(zero),      64'd1);
    @(posedge clk); #1;

    // Directed arithmetic cases, including carry chain and overflow.
    issue(32'd42, 32'd58, 1'b0, 1'b0, w);            drain();
    issue(32'd105, 32'd21, 1'b1, 1'b0, w);
    issue(32'd21, 32'd105, 1'b1, 1'b0, w);
    issue(32'd105, 32'd21, 1'b1, 1'b1, w);           // cin ignored on subtract
    issue(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, w);
    issue(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, w);
    issue(32'h8000_0000, 32'd1, 1'b1, 1'b0, w);
    issue(32'd0, 32'h8000_0000, 1'b1, 1'b0, w);
    drain();

    // Held result under backpressure, busy input ignored, then same-edge reuse.
    out_ready = 1'b0;
    issue(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, w);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b1; a = 32'd99; b = 32'd99;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(32'd1, 32'd2, 1'b0, 1'b0, w);
    chk("b2b_accept_waits", 64'(w), 64'd0);
    drain();

    // Reset while RUN is on slice k=2.
    issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, w);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum",       64'(sum),       64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
    chk("mid_rst_zero",      64'(zero),      64'd1);
    @(posedge clk); #1;
    issue(32'd3, 32'd4, 1'b0, 1'b0, w);
    drain();

    // Random operands with random consumer stalls.
    rnd_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      issue(pick(), pick(), 1'($urandom), 1'($urandom), w);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
    end
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
